// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Multi-mode test-pattern source sitting between the hvsync timing block and
// the HDMI encoder. It takes the raw timing counters and flags and produces
// registered RGB. Sync and active flags are delayed by one clock so that they
// stay aligned with the colour.
//
// Modes (latched on each vsync rising edge, so a switch never tears a frame):
//   0 : eight vertical stripes with a horizontal ramp (stripe 0 is dark grey)
//   1 : eight classic colour bars timed by counting active pixels
//   2 : black/white checkerboard
//   3 : white box on dark grey that bounces around the active area
module video_pattern_gen #(
    parameter int CW          = 8,
    parameter int CNT_W       = 12,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int STRIPE_LOG2 = 6,
    parameter int BAR_W       = 80,
    parameter int CHECK_LOG2  = 5,
    parameter int BOX_W       = 64,
    parameter int SPEED       = 4,
    parameter int DARK        = 'h10
) (
    input  logic             pixel_clk,
    input  logic             resetn,
    input  logic [1:0]       mode,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             active_in,
    input  logic [CNT_W-1:0] pixel_cnt,
    input  logic [CNT_W-1:0] line_cnt,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             active_out
);

    // Box arithmetic carries one extra bit so that position + step + size
    // never wraps before it is compared against the active extent.
    localparam int PW = CNT_W + 1;

    localparam logic [PW-1:0] SPEED_P  = PW'(SPEED);
    localparam logic [PW-1:0] BOX_W_P  = PW'(BOX_W);
    localparam logic [PW-1:0] H_SPAN_P = PW'(H_ACTIVE);
    localparam logic [PW-1:0] V_SPAN_P = PW'(V_ACTIVE);

    localparam logic [CW-1:0] DARK_C = CW'(DARK);
    localparam logic [CW-1:0] FULL_C = {CW{1'b1}};

    // Bar position counter only needs to reach BAR_W-1.
    localparam int BCW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic           vsync_prev_q, vsync_prev_d;
    logic [1:0]     mode_q, mode_d;
    logic [PW-1:0]  box_x_q, box_x_d;
    logic [PW-1:0]  box_y_q, box_y_d;
    // Direction flags: 0 = moving towards larger coordinates.
    logic           dir_x_dn_q, dir_x_dn_d;
    logic           dir_y_dn_q, dir_y_dn_d;
    logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]     bar_idx_q, bar_idx_d;

    logic [CW-1:0]  red_q, red_d;
    logic [CW-1:0]  green_q, green_d;
    logic [CW-1:0]  blue_q, blue_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           active_q, active_d;

    logic           frame_start;

    // One bounce step along a single axis. Result is {dir_dn_next, pos_next}.
    // Hitting the far edge clamps the box flush against it and reverses; the
    // near edge clamps to zero and reverses.
    function automatic logic [PW:0] box_step(
        input logic [PW-1:0] pos,
        input logic          dir_dn,
        input logic [PW-1:0] span
    );
        logic [PW-1:0] far_pos;
        logic [PW:0]   result;
        far_pos = span - BOX_W_P;
        if (!dir_dn) begin
            if (pos + SPEED_P + BOX_W_P > span) begin
                result = {1'b1, far_pos};
            end else begin
                result = {1'b0, pos + SPEED_P};
            end
        end else begin
            if (pos < SPEED_P) begin
                result = {1'b0, {PW{1'b0}}};
            end else begin
                result = {1'b1, pos - SPEED_P};
            end
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Frame-level control: vsync edge detect, mode latch, box animation
    // ------------------------------------------------------------------
    assign frame_start = vsync_in & ~vsync_prev_q;

    // Latch mode and move the box once per frame, at the vsync rising edge.
    always_comb begin
        vsync_prev_d = vsync_in;
        mode_d       = mode_q;
        box_x_d      = box_x_q;
        box_y_d      = box_y_q;
        dir_x_dn_d   = dir_x_dn_q;
        dir_y_dn_d   = dir_y_dn_q;
        if (frame_start) begin
            mode_d                  = mode;
            {dir_x_dn_d, box_x_d}   = box_step(box_x_q, dir_x_dn_q, H_SPAN_P);
            {dir_y_dn_d, box_y_d}   = box_step(box_y_q, dir_y_dn_q, V_SPAN_P);
        end
    end

    // Colour-bar position: counts active pixels, cleared by any blanking.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (!active_in) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            if (bar_idx_q != 3'd7) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end
        end else begin
            bar_cnt_d = bar_cnt_q + BCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-pattern colour terms (channel index 0 = R, 1 = G, 2 = B)
    // ------------------------------------------------------------------
    logic [2:0]         stripe;
    logic [CW-1:0]      ramp;
    logic [2:0][CW-1:0] stripe_col;
    logic [2:0]         bar_on;
    logic [2:0][CW-1:0] bar_col;
    logic               checker_on;
    logic               in_box;
    logic [PW-1:0]      pix_ext;
    logic [PW-1:0]      line_ext;

    assign stripe = pixel_cnt[STRIPE_LOG2+2:STRIPE_LOG2];

    // The in-stripe offset becomes the ramp, placed at the top of the channel
    // so a full stripe sweeps (nearly) the whole intensity range.
    generate
        if (STRIPE_LOG2 >= CW) begin : g_ramp_trunc
            assign ramp = pixel_cnt[STRIPE_LOG2-1 -: CW];
        end else begin : g_ramp_pad
            assign ramp = {pixel_cnt[STRIPE_LOG2-1:0], {(CW-STRIPE_LOG2){1'b0}}};
        end
    endgenerate

    // Bar order white, yellow, cyan, green, magenta, red, blue, black:
    // R is lit for indices with bit1 clear, G with bit2 clear, B with bit0 clear.
    assign bar_on = {~bar_idx_q[0], ~bar_idx_q[2], ~bar_idx_q[1]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            // Stripe s lights channel gi when the matching bit of s is set.
            assign stripe_col[gi] = (stripe == 3'd0) ? DARK_C :
                                    (stripe[2-gi] ? ramp : {CW{1'b0}});
            assign bar_col[gi]    = {CW{bar_on[gi]}};
        end
    endgenerate

    assign checker_on = pixel_cnt[CHECK_LOG2] ^ line_cnt[CHECK_LOG2];

    assign pix_ext  = {1'b0, pixel_cnt};
    assign line_ext = {1'b0, line_cnt};
    assign in_box   = (pix_ext  >= box_x_q) && (pix_ext  < box_x_q + BOX_W_P) &&
                      (line_ext >= box_y_q) && (line_ext < box_y_q + BOX_W_P);

    // Select the pixel colour for the current frame's mode; blank outside active.
    always_comb begin
        red_d    = '0;
        green_d  = '0;
        blue_d   = '0;
        hsync_d  = hsync_in;
        vsync_d  = vsync_in;
        active_d = active_in;
        if (active_in) begin
            case (mode_q)
                2'd0: begin
                    red_d   = stripe_col[0];
                    green_d = stripe_col[1];
                    blue_d  = stripe_col[2];
                end
                2'd1: begin
                    red_d   = bar_col[0];
                    green_d = bar_col[1];
                    blue_d  = bar_col[2];
                end
                2'd2: begin
                    if (checker_on) begin
                        red_d   = FULL_C;
                        green_d = FULL_C;
                        blue_d  = FULL_C;
                    end
                end
                default: begin
                    if (in_box) begin
                        red_d   = FULL_C;
                        green_d = FULL_C;
                        blue_d  = FULL_C;
                    end else begin
                        red_d   = DARK_C;
                        green_d = DARK_C;
                        blue_d  = DARK_C;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Frame control and bar counters, cleared by the synchronous reset.
    always_ff @(posedge pixel_clk) begin
        if (!resetn) begin
            vsync_prev_q <= 1'b0;
            mode_q       <= 2'd0;
            box_x_q      <= '0;
            box_y_q      <= '0;
            dir_x_dn_q   <= 1'b0;
            dir_y_dn_q   <= 1'b0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            mode_q       <= mode_d;
            box_x_q      <= box_x_d;
            box_y_q      <= box_y_d;
            dir_x_dn_q   <= dir_x_dn_d;
            dir_y_dn_q   <= dir_y_dn_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
        end
    end

    // Output stage: one clock of latency for colour and the aligned flags.
    always_ff @(posedge pixel_clk) begin
        if (!resetn) begin
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign active_out = active_q;

endmodule
